// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl
//   Memory/IO bus controller between the multicycle CPU memory port and the
//   system's block RAM, LED/switch GPIO and a down-counting timer. A request
//   taken in IDLE is latched, decoded by addr[31:28], given its wait states
//   in ACCESS and completed with a one-cycle mio_ready pulse in DONE.
//
// Parameters
//   RAM_WAIT  extra ACCESS cycles for RAM transactions (1..15)
//   AW        RAM word-address width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   cpu_req    access request from CPU (CPU_MIO)
//   mem_w      1 = write, 0 = read, sampled with cpu_req
//   addr       byte address from CPU
//   cpu_wdata  write data from CPU
//   cpu_rdata  registered read data to CPU (held until the next read)
//   mio_ready  one-cycle completion pulse
//   ram_addr   RAM word address (latched addr[AW+1:2])
//   ram_we     RAM write strobe, one cycle per RAM write
//   ram_wdata  latched write data
//   ram_rdata  synchronous RAM read data, valid one cycle after ram_addr
//   sw_in      switch inputs
//   led_out    LED register
//   timer_irq  one-cycle pulse after the timer decrements from 1 to 0
module mio_bus_ctrl #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned AW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          mem_w,
    input  logic [31:0]   addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          mio_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    input  logic [15:0]   sw_in,
    output logic [31:0]   led_out,
    output logic          timer_irq
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_GPIO, REG_TIMER, REG_NONE} region_t;

    state_t      state;
    region_t     region;
    region_t     req_region;
    logic        w_q;
    logic        first;
    logic [3:0]  wait_cnt;
    logic [31:0] timer_cnt;
    logic        timer_wr;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    // Region select only looks at the top nibble; the rest of the address
    // matters only for the RAM word address.
    assign unused_addr_bits = ^{addr[27:AW+2], addr[1:0]};

    always_comb begin
        case (addr[31:28])
            4'h0:    req_region = REG_RAM;
            4'hE:    req_region = REG_GPIO;
            4'hF:    req_region = REG_TIMER;
            default: req_region = REG_NONE;
        endcase
    end

    always_comb begin
        case (region)
            REG_RAM:   rd_mux = ram_rdata;
            REG_GPIO:  rd_mux = {16'h0000, sw_in};
            REG_TIMER: rd_mux = timer_cnt;
            default:   rd_mux = '0;
        endcase
    end

    // Timer loads at the end of the first ACCESS cycle of a timer write;
    // ram_wdata doubles as the latched write data for every region.
    assign timer_wr = (state == ACCESS) && first && w_q && (region == REG_TIMER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            region    <= REG_NONE;
            w_q       <= 1'b0;
            first     <= 1'b0;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            mio_ready <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            led_out   <= '0;
        end else begin
            ram_we    <= 1'b0;
            mio_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        ram_addr  <= addr[AW+1:2];
                        ram_wdata <= cpu_wdata;
                        w_q       <= mem_w;
                        region    <= req_region;
                        wait_cnt  <= (req_region == REG_RAM) ? 4'(RAM_WAIT) : 4'd0;
                        // Strobe is registered so it lines up with the first ACCESS cycle.
                        ram_we    <= mem_w && (req_region == REG_RAM);
                        first     <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    first <= 1'b0;
                    if (first && w_q && (region == REG_GPIO)) begin
                        led_out <= ram_wdata;
                    end
                    if (wait_cnt == 4'd0) begin
                        if (!w_q) begin
                            cpu_rdata <= rd_mux;
                        end
                        mio_ready <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A CPU load wins over the decrement; only a decrement from 1 fires the irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_cnt <= '0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= 1'b0;
            if (timer_wr) begin
                timer_cnt <= ram_wdata;
            end else if (timer_cnt != 32'd0) begin
                timer_cnt <= timer_cnt - 32'd1;
                if (timer_cnt == 32'd1) begin
                    timer_irq <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Testbench for mio_bus_ctrl: a transaction-level timing model checks the
// default build every cycle under directed and random traffic; a second
// instance built with RAM_WAIT=4 gets directed latency checks.
module tb_mio_bus_ctrl;

    localparam int unsigned AW  = 10;
    localparam int unsigned RW0 = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_req1, mem_w;
    logic [31:0]   addr, cpu_wdata;
    logic [15:0]   sw_in;

    logic [31:0]   cpu_rdata0, ram_wdata0, led_out0;
    logic [31:0]   ram_rdata0;
    logic          mio_ready0, ram_we0, timer_irq0;
    logic [AW-1:0] ram_addr0;

    logic [31:0]   cpu_rdata1, ram_wdata1, led_out1;
    logic [31:0]   ram_rdata1;
    logic          mio_ready1, ram_we1, timer_irq1;
    logic [AW-1:0] ram_addr1;

    mio_bus_ctrl #(.RAM_WAIT(RW0), .AW(AW)) dut0 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr(addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .mio_ready(mio_ready0),
        .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0), .sw_in(sw_in), .led_out(led_out0), .timer_irq(timer_irq0)
    );

    mio_bus_ctrl #(.RAM_WAIT(4), .AW(AW)) dut1 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req1), .mem_w(mem_w), .addr(addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .mio_ready(mio_ready1),
        .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .sw_in(sw_in), .led_out(led_out1), .timer_irq(timer_irq1)
    );

    // Synchronous block RAMs attached to each instance
    logic [31:0] bram0 [0:(1<<AW)-1];
    logic [31:0] bram1 [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we0) bram0[ram_addr0] <= ram_wdata0;
        ram_rdata0 <= bram0[ram_addr0];
        if (ram_we1) bram1[ram_addr1] <= ram_wdata1;
        ram_rdata1 <= bram1[ram_addr1];
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A request accepted at edge t with latency L (RAM: RW0+2, else 2):
    //   ram_we high for the cycle after edge t (RAM write only),
    //   writes land at edge t+1, read data and mio_ready appear at edge t+L-1,
    //   the controller accepts again from edge t+L+1.
    logic [31:0]   mmem [0:(1<<AW)-1];
    int unsigned   n;
    bit            pend, idle, tw;
    int unsigned   t_acc, lat_m, region;
    bit            p_w;
    logic [31:0]   p_addr, p_wdata, m_timer;
    logic [31:0]   e_rdata, e_led, e_wdata;
    logic [AW-1:0] e_raddr;
    logic          e_rdy, e_we, e_irq;

    function automatic int unsigned region_of(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'hE:    return 1;
            4'hF:    return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0; pend = 0; m_timer = '0;
            e_rdata = '0; e_led = '0; e_wdata = '0; e_raddr = '0;
            e_rdy = 0; e_we = 0; e_irq = 0;
        end else begin
            n++;
            idle  = !pend;
            e_rdy = 0; e_we = 0; e_irq = 0;
            if (pend && n == t_acc + lat_m - 1) begin
                e_rdy = 1;
                if (!p_w) begin
                    case (region)
                        0:       e_rdata = mmem[p_addr[AW+1:2]];
                        1:       e_rdata = {16'h0000, sw_in};
                        2:       e_rdata = m_timer;
                        default: e_rdata = '0;
                    endcase
                end
            end
            tw = 0;
            if (pend && p_w && n == t_acc + 1) begin
                case (region)
                    0:       mmem[p_addr[AW+1:2]] = p_wdata;
                    1:       e_led = p_wdata;
                    2:       begin m_timer = p_wdata; tw = 1; end
                    default: ;
                endcase
            end
            if (!tw && m_timer != 0) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) e_irq = 1;
            end
            if (pend && n == t_acc + lat_m) pend = 0;
            if (idle && cpu_req) begin
                pend    = 1;
                t_acc   = n;
                p_addr  = addr;
                p_w     = mem_w;
                p_wdata = cpu_wdata;
                region  = region_of(addr);
                lat_m   = (region == 0) ? RW0 + 2 : 2;
                e_raddr = addr[AW+1:2];
                e_wdata = cpu_wdata;
                e_we    = mem_w && (region == 0);
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mio_ready", {31'b0, mio_ready0}, {31'b0, e_rdy});
            chk("cpu_rdata", cpu_rdata0, e_rdata);
            chk("ram_we", {31'b0, ram_we0}, {31'b0, e_we});
            chk("ram_addr", 32'(ram_addr0), 32'(e_raddr));
            chk("ram_wdata", ram_wdata0, e_wdata);
            chk("led_out", led_out0, e_led);
            chk("timer_irq", {31'b0, timer_irq0}, {31'b0, e_irq});
        end
    end

    int unsigned irq_seen0 = 0;
    always @(negedge clk) if (timer_irq0) irq_seen0++;

    // Called at a negedge with the selected DUT idle. Returns edges from the
    // accepting edge to the mio_ready sample; unless held, cpu_req drops after
    // one cycle and the task returns once the DUT is idle again.
    task automatic xact(input bit which, input logic [31:0] a, input bit w, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd, output int lat,
                        output int we_cnt, output logic [AW-1:0] we_addr);
        addr = a; mem_w = w; cpu_wdata = d;
        if (which) cpu_req1 = 1'b1; else cpu_req = 1'b1;
        lat = 0; we_cnt = 0; we_addr = '0; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) begin cpu_req = 1'b0; cpu_req1 = 1'b0; end
            if (which ? ram_we1 : ram_we0) begin
                we_cnt++;
                we_addr = which ? ram_addr1 : ram_addr0;
            end
            if (which ? mio_ready1 : mio_ready0) begin
                lat = k;
                rd  = which ? cpu_rdata1 : cpu_rdata0;
                break;
            end
        end
        chk("xact_completes", {31'b0, lat != 0}, 32'd1);
        if (!hold) @(negedge clk);
    endtask

    logic [31:0]   rd;
    int            lat, wec;
    logic [AW-1:0] wea;
    int unsigned   base, first_irq, rsel;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            bram0[i] = '0; bram1[i] = '0; mmem[i] = '0;
        end
        cpu_req = 0; cpu_req1 = 0; mem_w = 0; addr = '0; cpu_wdata = '0; sw_in = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_rdata", cpu_rdata0, 32'h0);
        chk("reset_led", led_out0, 32'h0);
        chk("reset_ready", {31'b0, mio_ready0}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // RAM write then read
        xact(0, 32'h0000_0010, 1, 32'hDEAD_BEEF, 0, rd, lat, wec, wea);
        chk("ram_wr_lat", 32'(lat), 32'd3);
        chk("ram_wr_we_pulses", 32'(wec), 32'd1);
        chk("ram_wr_we_addr", 32'(wea), 32'd4);
        xact(0, 32'h0000_0010, 0, 32'h0, 0, rd, lat, wec, wea);
        chk("ram_rd_data", rd, 32'hDEAD_BEEF);
        chk("ram_rd_lat", 32'(lat), 32'd3);
        chk("ram_rd_no_we", 32'(wec), 32'd0);

        // GPIO
        xact(0, 32'hE000_0000, 1, 32'h0000_00A5, 0, rd, lat, wec, wea);
        chk("gpio_wr_lat", 32'(lat), 32'd2);
        chk("gpio_led", led_out0, 32'h0000_00A5);
        sw_in = 16'h1234;
        xact(0, 32'hE000_0004, 0, 32'h0, 0, rd, lat, wec, wea);
        chk("gpio_rd_data", rd, 32'h0000_1234);

        // Timer: load 5, irq exactly once, 5 edges after the load lands
        base = irq_seen0; first_irq = 0;
        xact(0, 32'hF000_0000, 1, 32'd5, 0, rd, lat, wec, wea);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (timer_irq0 && first_irq == 0) first_irq = j;
        end
        chk("timer_irq_pos", first_irq, 32'd4);
        chk("timer_irq_count", irq_seen0 - base, 32'd1);

        // Timer read right after a load of 100
        xact(0, 32'hF000_0000, 1, 32'd100, 0, rd, lat, wec, wea);
        xact(0, 32'hF123_4568, 0, 32'h0, 0, rd, lat, wec, wea);
        chk("timer_rd", rd, 32'd98);

        // Load 0 lands while the counter is at 1: no irq
        xact(0, 32'hF000_0000, 1, 32'd3, 0, rd, lat, wec, wea);
        base = irq_seen0;
        xact(0, 32'hF000_0000, 1, 32'd0, 0, rd, lat, wec, wea);
        repeat (8) @(negedge clk);
        chk("timer_zero_no_irq", irq_seen0 - base, 32'd0);

        // Back-to-back with cpu_req held: RAM 0x0 then unmapped
        xact(0, 32'h0000_0000, 1, 32'h1234_5678, 0, rd, lat, wec, wea);
        xact(0, 32'h0000_0000, 0, 32'h0, 1, rd, lat, wec, wea);
        chk("b2b_first", rd, 32'h1234_5678);
        xact(0, 32'h5000_0000, 0, 32'h0, 1, rd, lat, wec, wea);
        chk("b2b_second", rd, 32'h0);
        chk("b2b_spacing", 32'(lat), 32'd3);
        cpu_req = 0;
        @(negedge clk);

        // Reset in the first ACCESS cycle of a RAM write
        addr = 32'h0000_0020; mem_w = 1; cpu_wdata = 32'hCAFE_F00D; cpu_req = 1;
        @(negedge clk);
        cpu_req = 0;
        chk("rst_pre_we", {31'b0, ram_we0}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", {31'b0, mio_ready0}, 32'd0);
        chk("rst_we", {31'b0, ram_we0}, 32'd0);
        chk("rst_rdata", cpu_rdata0, 32'd0);
        chk("rst_raddr", 32'(ram_addr0), 32'd0);
        chk("rst_wdata", ram_wdata0, 32'd0);
        chk("rst_led", led_out0, 32'd0);
        chk("rst_irq", {31'b0, timer_irq0}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_ready", {31'b0, mio_ready0}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        xact(0, 32'h0000_0020, 0, 32'h0, 0, rd, lat, wec, wea);
        chk("rst_no_write", rd, 32'h0);
        chk("rst_after_lat", 32'(lat), 32'd3);

        // RAM_WAIT=4 build
        xact(1, 32'h0000_0040, 1, 32'h0BAD_CAFE, 0, rd, lat, wec, wea);
        chk("rw4_wr_lat", 32'(lat), 32'd6);
        chk("rw4_we_pulses", 32'(wec), 32'd1);
        xact(1, 32'h0000_0040, 0, 32'h0, 0, rd, lat, wec, wea);
        chk("rw4_rd_lat", 32'(lat), 32'd6);
        chk("rw4_rd_data", rd, 32'h0BAD_CAFE);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            mem_w     = $urandom_range(0, 1) == 1;
            cpu_wdata = $urandom;
            sw_in     = 16'($urandom);
            rsel      = $urandom_range(0, 7);
            if (rsel <= 2) begin
                addr = {4'h0, 16'($urandom), 6'b0, 4'($urandom), 2'($urandom)};
            end else if (rsel == 3) begin
                addr = {4'hE, 28'($urandom)};
            end else if (rsel <= 5) begin
                addr = {4'hF, 28'($urandom)};
                cpu_wdata = $urandom_range(0, 20);
            end else begin
                addr = {4'($urandom_range(1, 13)), 28'($urandom)};
            end
            @(negedge clk);
        end
        cpu_req = 0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
